// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage of the RV32I core.
// Holds the MEM-stage result, aligns and extends load data, selects the
// writeback value, and drives the register-file write port.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  in_valid,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [2:0]            in_wbsel,
  input  logic [XLEN-1:0]       in_alu_out,
  input  logic                  in_br_en,
  input  logic [XLEN-1:0]       in_u_imm,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_mem_rdata,
  input  logic [1:0]            in_addr_lo,
  output logic                  rf_load,
  output logic [REG_ADDR_W-1:0] rf_dest,
  output logic [XLEN-1:0]       rf_in,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_pc,
  output logic [63:0]           instret
);

  localparam int unsigned CNT_W = 64;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_BR   = 3'd1;
  localparam logic [2:0] WB_UIMM = 3'd2;
  localparam logic [2:0] WB_LOAD = 3'd3;
  localparam logic [2:0] WB_PC4  = 3'd4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic                  valid_q;
  logic                  done_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0]            wbsel_q;
  logic [XLEN-1:0]       alu_q;
  logic                  br_en_q;
  logic [XLEN-1:0]       u_imm_q;
  logic [XLEN-1:0]       pc_q;
  logic [2:0]            funct3_q;
  logic [XLEN-1:0]       mem_rdata_q;
  logic [1:0]            addr_lo_q;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [XLEN-1:0]       ld_data;
  logic [XLEN-1:0]       wb_data;

  // Stage register: reset > flush > stall > capture.
  // done_q marks a held entry that has already written/retired.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
      wbsel_q     <= '0;
      alu_q       <= '0;
      br_en_q     <= 1'b0;
      u_imm_q     <= '0;
      pc_q        <= '0;
      funct3_q    <= '0;
      mem_rdata_q <= '0;
      addr_lo_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (stall_i) begin
      done_q <= 1'b1;
    end else begin
      valid_q     <= in_valid;
      done_q      <= 1'b0;
      regwrite_q  <= in_regwrite;
      rd_q        <= in_rd;
      wbsel_q     <= in_wbsel;
      alu_q       <= in_alu_out;
      br_en_q     <= in_br_en;
      u_imm_q     <= in_u_imm;
      pc_q        <= in_pc;
      funct3_q    <= in_funct3;
      mem_rdata_q <= in_mem_rdata;
      addr_lo_q   <= in_addr_lo;
    end
  end

  // Load alignment and sign/zero extension.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_data = mem_rdata_q;
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rdata_q[7:0];
      2'd1:    ld_byte = mem_rdata_q[15:8];
      2'd2:    ld_byte = mem_rdata_q[23:16];
      default: ld_byte = mem_rdata_q[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
    case (funct3_q)
      F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LW:   ld_data = mem_rdata_q;
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata_q;
    endcase
  end

  // Writeback source select.
  always_comb begin
    wb_data = '0;
    case (wbsel_q)
      WB_ALU:  wb_data = alu_q;
      WB_BR:   wb_data = {{(XLEN-1){1'b0}}, br_en_q};
      WB_UIMM: wb_data = u_imm_q;
      WB_LOAD: wb_data = ld_data;
      WB_PC4:  wb_data = XLEN'(pc_q + XLEN'(4));
      default: wb_data = '0;
    endcase
  end

  // Register-file write port and retire signals; each entry fires once.
  always_comb begin
    rf_load  = valid_q & regwrite_q & (rd_q != '0) & ~done_q;
    rf_dest  = rf_load ? rd_q : '0;
    rf_in    = rf_load ? wb_data : '0;
    wb_valid = valid_q & ~done_q;
    wb_pc    = pc_q;
  end

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (wb_valid) begin
      instret_q <= CNT_W'(instret_q + CNT_W'(1));
    end
  end

  assign instret = instret_q;
`else
  assign instret = CNT_W'(0);
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a record model.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        in_valid;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [2:0]  in_wbsel;
  logic [31:0] in_alu_out;
  logic        in_br_en;
  logic [31:0] in_u_imm;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic [31:0] in_mem_rdata;
  logic [1:0]  in_addr_lo;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_rd(in_rd),
    .in_wbsel(in_wbsel), .in_alu_out(in_alu_out), .in_br_en(in_br_en),
    .in_u_imm(in_u_imm), .in_pc(in_pc), .in_funct3(in_funct3),
    .in_mem_rdata(in_mem_rdata), .in_addr_lo(in_addr_lo),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instruction currently held, and whether it has retired.
  typedef struct {
    bit          valid;
    bit          retired;
    bit          regwrite;
    bit [4:0]    rd;
    bit [2:0]    wbsel;
    bit [31:0]   alu;
    bit          br_en;
    bit [31:0]   uimm;
    bit [31:0]   pc;
    bit [2:0]    f3;
    bit [31:0]   rdata;
    bit [1:0]    off;
  } instr_t;

  instr_t      m;
  bit          m_just_reset;
  bit [63:0]   exp_instret;

  typedef struct {
    string       name;
    bit          regwrite;
    bit [4:0]    rd;
    bit [2:0]    wbsel;
    bit [31:0]   alu;
    bit          br_en;
    bit [31:0]   uimm;
    bit [31:0]   pc;
    bit [2:0]    f3;
    bit [31:0]   rdata;
    bit [1:0]    off;
    bit          exp_load;
    bit [31:0]   exp_in;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result as the ISA describes it: pick a byte/halfword by offset,
  // then extend by arithmetic rather than by bit replication.
  function automatic bit [31:0] load_value(bit [31:0] w, bit [2:0] f3, bit [1:0] off);
    bit [31:0] b;
    bit [31:0] h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? 32'(b - 32'd256)   : b;
      3'b001:  return (h >= 32'd32768) ? 32'(h - 32'd65536) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit [31:0] wb_value(instr_t r);
    case (r.wbsel)
      3'd0:    return r.alu;
      3'd1:    return r.br_en ? 32'd1 : 32'd0;
      3'd2:    return r.uimm;
      3'd3:    return load_value(r.rdata, r.f3, r.off);
      3'd4:    return 32'(r.pc + 32'd4);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit exp_retire(instr_t r);
    return r.valid && !r.retired;
  endfunction

  function automatic bit exp_write(instr_t r);
    return exp_retire(r) && r.regwrite && (r.rd != 5'd0);
  endfunction

  // One clock: advance the model with the applied inputs, then compare.
  task automatic cycle();
    if (!rst) exp_instret = 64'd0;
    else if (exp_retire(m)) exp_instret = exp_instret + 64'd1;
    @(posedge clk);
    if (!rst) begin
      m = '{default: '0};
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      if (flush_i) begin
        m.valid = 1'b0;
      end else if (stall_i) begin
        if (m.valid) m.retired = 1'b1;
      end else begin
        m.valid    = in_valid;
        m.retired  = 1'b0;
        m.regwrite = in_regwrite;
        m.rd       = in_rd;
        m.wbsel    = in_wbsel;
        m.alu      = in_alu_out;
        m.br_en    = in_br_en;
        m.uimm     = in_u_imm;
        m.pc       = in_pc;
        m.f3       = in_funct3;
        m.rdata    = in_mem_rdata;
        m.off      = in_addr_lo;
      end
    end
    #1;
    chk("rf_load",  64'(rf_load),  64'(exp_write(m)));
    chk("rf_dest",  64'(rf_dest),  exp_write(m) ? 64'(m.rd) : 64'd0);
    chk("rf_in",    64'(rf_in),    exp_write(m) ? 64'(wb_value(m)) : 64'd0);
    chk("wb_valid", 64'(wb_valid), 64'(exp_retire(m)));
    if (exp_retire(m) || m_just_reset) chk("wb_pc", 64'(wb_pc), 64'(m.pc));
`ifdef WB_INSTRET_EN
    chk("instret", instret, exp_instret);
`else
    chk("instret", instret, 64'd0);
`endif
  endtask

  task automatic set_in(input bit v, input bit rw, input bit [4:0] rd, input bit [2:0] sel,
                        input bit [31:0] alu, input bit br, input bit [31:0] uimm,
                        input bit [31:0] pc, input bit [2:0] f3, input bit [31:0] rdata,
                        input bit [1:0] off);
    in_valid = v; in_regwrite = rw; in_rd = rd; in_wbsel = sel; in_alu_out = alu;
    in_br_en = br; in_u_imm = uimm; in_pc = pc; in_funct3 = f3;
    in_mem_rdata = rdata; in_addr_lo = off;
  endtask

  task automatic rand_in();
    set_in(($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom), 3'($urandom),
           $urandom, 1'($urandom), $urandom, $urandom, 3'($urandom), $urandom,
           2'($urandom));
  endtask

  function automatic vec_t mk(string n, bit rw, bit [4:0] rd, bit [2:0] sel, bit [31:0] alu,
                              bit br, bit [31:0] uimm, bit [31:0] pc, bit [2:0] f3,
                              bit [31:0] rdata, bit [1:0] off, bit el, bit [31:0] ei);
    vec_t v;
    v.name = n; v.regwrite = rw; v.rd = rd; v.wbsel = sel; v.alu = alu; v.br_en = br;
    v.uimm = uimm; v.pc = pc; v.f3 = f3; v.rdata = rdata; v.off = off;
    v.exp_load = el; v.exp_in = ei;
    return v;
  endfunction

  initial begin
    m = '{default: '0};
    m_just_reset = 1'b0;
    exp_instret = 64'd0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    rst = 1'b0;

    vecs.push_back(mk("lb_off0",   1, 5'd1, 3'd3, 0, 0, 0, 32'h100, 3'b000, 32'h80F17F82, 2'd0, 1, 32'hFFFFFF82));
    vecs.push_back(mk("lbu_off3",  1, 5'd2, 3'd3, 0, 0, 0, 32'h104, 3'b100, 32'h80F17F82, 2'd3, 1, 32'h00000080));
    vecs.push_back(mk("lh_off2",   1, 5'd3, 3'd3, 0, 0, 0, 32'h108, 3'b001, 32'h80F17F82, 2'd2, 1, 32'hFFFF80F1));
    vecs.push_back(mk("lhu_off1",  1, 5'd4, 3'd3, 0, 0, 0, 32'h10C, 3'b101, 32'h80F17F82, 2'd1, 1, 32'h00007F82));
    vecs.push_back(mk("lw",        1, 5'd5, 3'd3, 0, 0, 0, 32'h110, 3'b010, 32'h80F17F82, 2'd3, 1, 32'h80F17F82));
    vecs.push_back(mk("lb_off1",   1, 5'd6, 3'd3, 0, 0, 0, 32'h114, 3'b000, 32'h80F17F82, 2'd1, 1, 32'h0000007F));
    vecs.push_back(mk("lh_off3",   1, 5'd7, 3'd3, 0, 0, 0, 32'h118, 3'b001, 32'h80F17F82, 2'd3, 1, 32'hFFFF80F1));
    vecs.push_back(mk("ld_f3_011", 1, 5'd8, 3'd3, 0, 0, 0, 32'h11C, 3'b011, 32'h80F17F82, 2'd1, 1, 32'h80F17F82));
    vecs.push_back(mk("pc4_wrap",  1, 5'd9, 3'd4, 0, 0, 0, 32'hFFFFFFFC, 3'b000, 0, 2'd0, 1, 32'h00000000));
    vecs.push_back(mk("br_en",     1, 5'd10, 3'd1, 32'h55, 1, 0, 32'h120, 3'b000, 0, 2'd0, 1, 32'h00000001));
    vecs.push_back(mk("u_imm",     1, 5'd11, 3'd2, 32'h55, 0, 32'hABCDE000, 32'h124, 3'b000, 0, 2'd0, 1, 32'hABCDE000));
    vecs.push_back(mk("sel_6",     1, 5'd12, 3'd6, 32'h55, 1, 32'h77, 32'h128, 3'b000, 32'h99, 2'd0, 1, 32'h00000000));
    vecs.push_back(mk("no_rw",     0, 5'd13, 3'd0, 32'h55, 0, 0, 32'h12C, 3'b000, 0, 2'd0, 0, 32'h00000000));
    vecs.push_back(mk("rd0",       1, 5'd0, 3'd0, 32'h1234, 0, 0, 32'h130, 3'b000, 0, 2'd0, 0, 32'h00000000));

    // Reset for two cycles with random inputs: everything reads zero.
    for (int i = 0; i < 2; i++) begin
      rand_in();
      stall_i = 1'($urandom);
      flush_i = 1'($urandom);
      cycle();
    end
    chk("rst_rf_load",  64'(rf_load),  64'd0);
    chk("rst_rf_in",    64'(rf_in),    64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_pc",    64'(wb_pc),    64'd0);
    chk("rst_instret",  instret,       64'd0);
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;

    // First capture after reset, one cycle to the write.
    set_in(1, 1, 5'd5, 3'd0, 32'hDEADBEEF, 0, 0, 32'h40, 3'b000, 0, 2'd0);
    cycle();
    chk("first_load",  64'(rf_load),  64'd1);
    chk("first_dest",  64'(rf_dest),  64'd5);
    chk("first_in",    64'(rf_in),    64'hDEADBEEF);
    chk("first_valid", 64'(wb_valid), 64'd1);

    // Directed vector table.
    foreach (vecs[i]) begin
      set_in(1, vecs[i].regwrite, vecs[i].rd, vecs[i].wbsel, vecs[i].alu, vecs[i].br_en,
             vecs[i].uimm, vecs[i].pc, vecs[i].f3, vecs[i].rdata, vecs[i].off);
      cycle();
      chk({vecs[i].name, "_load"}, 64'(rf_load), 64'(vecs[i].exp_load));
      chk({vecs[i].name, "_in"},   64'(rf_in),   64'(vecs[i].exp_in));
      chk({vecs[i].name, "_wbv"},  64'(wb_valid), 64'd1);
    end

    // Stall: write and retire exactly once.
    set_in(1, 1, 5'd7, 3'd0, 32'hCAFE0007, 0, 0, 32'h200, 3'b000, 0, 2'd0);
    cycle();
    chk("stall_first_load", 64'(rf_load), 64'd1);
    chk("stall_first_wbv",  64'(wb_valid), 64'd1);
    stall_i = 1'b1;
    rand_in();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_hold_load", 64'(rf_load),  64'd0);
      chk("stall_hold_wbv",  64'(wb_valid), 64'd0);
    end
    stall_i = 1'b0;

    // Flush during stall kills the held entry.
    set_in(1, 1, 5'd3, 3'd0, 32'h33, 0, 0, 32'h300, 3'b000, 0, 2'd0);
    cycle();
    stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    chk("flush_load", 64'(rf_load),  64'd0);
    chk("flush_wbv",  64'(wb_valid), 64'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // Flush at capture: the presented instruction never writes.
    set_in(1, 1, 5'd9, 3'd0, 32'h99, 0, 0, 32'h400, 3'b000, 0, 2'd0);
    flush_i = 1'b1;
    cycle();
    chk("flush_cap_load", 64'(rf_load), 64'd0);
    flush_i = 1'b0;

    // Reset while an entry is held under stall.
    set_in(1, 1, 5'd4, 3'd0, 32'h44, 0, 0, 32'h500, 3'b000, 0, 2'd0);
    stall_i = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_stall_load", 64'(rf_load),  64'd0);
    chk("rst_stall_wbv",  64'(wb_valid), 64'd0);
    rst = 1'b1; stall_i = 1'b0;

    // Randomized traffic checked against the model.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      stall_i = ($urandom % 10) < 3;
      flush_i = ($urandom % 10) == 0;
      rst     = ($urandom % 40) != 0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
